// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
package ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        ALU_WB,
        MEM_ADDR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        BRANCH,
        TRAP
    } state_e;

    typedef logic [1:0] cause_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RFUNC = 2'b10;
    localparam logic [1:0] ALUOP_IFUNC = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    localparam cause_t CAUSE_NONE    = 2'b00;
    localparam cause_t CAUSE_ILLEGAL = 2'b01;
    localparam cause_t CAUSE_TIMEOUT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       imem_read;
        logic       ir_write;
        logic       load_reg_a;
        logic       load_reg_b;
        logic       load_aout;
        logic       reg_write;
        logic       mem_to_reg;
        logic       dmem_read;
        logic       dmem_write;
        logic       load_mdr;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_flags_t;

    // DECODE successor; TRAP marks an opcode this datapath cannot execute.
    function automatic state_e dispatch_state(input logic [6:0] op);
        case (op)
            OP_RTYPE:          return EXEC_R;
            OP_ITYPE:          return EXEC_I;
            OP_LOAD, OP_STORE: return MEM_ADDR;
            OP_BRANCH:         return BRANCH;
            default:           return TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface multicycle_ctrl_fsm_if
    import ctrl_pkg::*;
#(
    parameter int RET_W = 64
);
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             alu_zero;
    logic             imem_ready;
    logic             dmem_ready;

    logic             PCWrite;
    logic             PCWriteCond;
    logic             IMemRead;
    logic             IRWrite;
    logic             LoadRegA;
    logic             LoadRegB;
    logic             LoadAOut;
    logic             RegWrite;
    logic             MemToReg;
    logic             DMemRead;
    logic             DMemWrite;
    logic             LoadMDR;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSource;
    logic             branch_taken;
    logic             trap;
    cause_t           trap_cause;
    logic [RET_W-1:0] instret;

    modport master (
        input  opcode, funct3, alu_zero, imem_ready, dmem_ready,
        output PCWrite, PCWriteCond, IMemRead, IRWrite, LoadRegA, LoadRegB,
               LoadAOut, RegWrite, MemToReg, DMemRead, DMemWrite, LoadMDR,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, branch_taken, trap,
               trap_cause, instret
    );

    modport slave (
        output opcode, funct3, alu_zero, imem_ready, dmem_ready,
        input  PCWrite, PCWriteCond, IMemRead, IRWrite, LoadRegA, LoadRegB,
               LoadAOut, RegWrite, MemToReg, DMemRead, DMemWrite, LoadMDR,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, branch_taken, trap,
               trap_cause, instret
    );

endinterface

// File: rtl/multicycle_ctrl_fsm_out_decode.sv
// Combinational state-to-flags decoder; ready inputs qualify the handshake strobes.
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  state_e      i_state,
    input  logic        i_imem_ready,
    input  logic        i_dmem_ready,
    input  logic [2:0]  i_funct3,
    input  logic        i_alu_zero,
    output ctrl_flags_t o_flags,
    output logic        o_branch_taken
);

    always_comb begin
        o_flags = '0;
        case (i_state)
            FETCH: begin
                o_flags.imem_read = 1'b1;
                o_flags.alu_src_b = SRCB_FOUR;
                o_flags.alu_op    = ALUOP_ADD;
                o_flags.pc_source = PCSRC_ALU;
                o_flags.ir_write  = i_imem_ready;
                o_flags.pc_write  = i_imem_ready;
            end
            DECODE: begin
                // Branch target PC+imm is parked in ALUOut while operands load.
                o_flags.load_reg_a = 1'b1;
                o_flags.load_reg_b = 1'b1;
                o_flags.alu_src_b  = SRCB_IMM;
                o_flags.alu_op     = ALUOP_ADD;
                o_flags.load_aout  = 1'b1;
            end
            EXEC_R: begin
                o_flags.alu_src_a = 1'b1;
                o_flags.alu_src_b = SRCB_REG;
                o_flags.alu_op    = ALUOP_RFUNC;
                o_flags.load_aout = 1'b1;
            end
            EXEC_I: begin
                o_flags.alu_src_a = 1'b1;
                o_flags.alu_src_b = SRCB_IMM;
                o_flags.alu_op    = ALUOP_IFUNC;
                o_flags.load_aout = 1'b1;
            end
            ALU_WB: begin
                o_flags.reg_write = 1'b1;
            end
            MEM_ADDR: begin
                o_flags.alu_src_a = 1'b1;
                o_flags.alu_src_b = SRCB_IMM;
                o_flags.alu_op    = ALUOP_ADD;
                o_flags.load_aout = 1'b1;
            end
            MEM_READ: begin
                o_flags.dmem_read = 1'b1;
                o_flags.load_mdr  = i_dmem_ready;
            end
            MEM_WB: begin
                o_flags.reg_write  = 1'b1;
                o_flags.mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                o_flags.dmem_write = 1'b1;
            end
            BRANCH: begin
                o_flags.alu_src_a     = 1'b1;
                o_flags.alu_src_b     = SRCB_REG;
                o_flags.alu_op        = ALUOP_SUB;
                o_flags.pc_write_cond = 1'b1;
                o_flags.pc_source     = PCSRC_ALUOUT;
            end
            default: ;
        endcase
    end

    // BNE inverts the zero test; every other funct3 is treated as BEQ.
    assign o_branch_taken = o_flags.pc_write_cond & (i_alu_zero ^ (i_funct3 == F3_BNE));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RISC-V control FSM: sequencing, memory-wait timeout, sticky trap, instret.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int RET_W       = 64
)(
    input  logic                  clk,
    input  logic                  reset,
    multicycle_ctrl_fsm_if.master bus
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_e           r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [RET_W-1:0] r_instret;
    logic             r_trap;
    cause_t           r_trap_cause;

    ctrl_flags_t w_flags;
    logic        w_branch_taken;
    logic        w_in_wait;
    logic        w_ready;
    logic        w_timeout;
    logic        w_illegal;
    logic        w_retire;

    ctrl_out_decode u_out_decode (
        .i_state        (r_state),
        .i_imem_ready   (bus.imem_ready),
        .i_dmem_ready   (bus.dmem_ready),
        .i_funct3       (bus.funct3),
        .i_alu_zero     (bus.alu_zero),
        .o_flags        (w_flags),
        .o_branch_taken (w_branch_taken)
    );

    assign w_in_wait = (r_state == FETCH) || (r_state == MEM_READ) || (r_state == MEM_WRITE);
    assign w_ready   = (r_state == FETCH) ? bus.imem_ready : bus.dmem_ready;
    // A ready arriving on the limit cycle still wins over the timeout.
    assign w_timeout = (MEM_TIMEOUT != 0) && w_in_wait && !w_ready &&
                       (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign w_illegal = (r_state == DECODE) && (dispatch_state(bus.opcode) == TRAP);
    assign w_retire  = (r_state == ALU_WB) || (r_state == MEM_WB) || (r_state == BRANCH) ||
                       ((r_state == MEM_WRITE) && bus.dmem_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_wait_cnt   <= '0;
            r_instret    <= '0;
            r_trap       <= 1'b0;
            r_trap_cause <= CAUSE_NONE;
        end else begin
            // Outside the wait states the counter sits at zero, so entry always starts fresh.
            if (w_in_wait && !w_ready && !w_timeout)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            else
                r_wait_cnt <= '0;

            if (w_retire)
                r_instret <= r_instret + 1'b1;

            case (r_state)
                IDLE:      r_state <= FETCH;
                FETCH:     if (w_ready) r_state <= DECODE;
                DECODE:    r_state <= dispatch_state(bus.opcode);
                EXEC_R,
                EXEC_I:    r_state <= ALU_WB;
                ALU_WB,
                MEM_WB,
                BRANCH:    r_state <= FETCH;
                MEM_ADDR:  r_state <= (bus.opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
                MEM_READ:  if (w_ready) r_state <= MEM_WB;
                MEM_WRITE: if (w_ready) r_state <= FETCH;
                default:   r_state <= TRAP;
            endcase

            if (w_illegal) begin
                r_trap       <= 1'b1;
                r_trap_cause <= CAUSE_ILLEGAL;
            end
            if (w_timeout) begin
                r_state      <= TRAP;
                r_trap       <= 1'b1;
                r_trap_cause <= CAUSE_TIMEOUT;
            end
        end
    end

    assign bus.PCWrite      = w_flags.pc_write;
    assign bus.PCWriteCond  = w_flags.pc_write_cond;
    assign bus.IMemRead     = w_flags.imem_read;
    assign bus.IRWrite      = w_flags.ir_write;
    assign bus.LoadRegA     = w_flags.load_reg_a;
    assign bus.LoadRegB     = w_flags.load_reg_b;
    assign bus.LoadAOut     = w_flags.load_aout;
    assign bus.RegWrite     = w_flags.reg_write;
    assign bus.MemToReg     = w_flags.mem_to_reg;
    assign bus.DMemRead     = w_flags.dmem_read;
    assign bus.DMemWrite    = w_flags.dmem_write;
    assign bus.LoadMDR      = w_flags.load_mdr;
    assign bus.ALUSrcA      = w_flags.alu_src_a;
    assign bus.ALUSrcB      = w_flags.alu_src_b;
    assign bus.ALUOp        = w_flags.alu_op;
    assign bus.PCSource     = w_flags.pc_source;
    assign bus.branch_taken = w_branch_taken;
    assign bus.trap         = r_trap;
    assign bus.trap_cause   = r_trap_cause;
    assign bus.instret      = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed, table-driven bench for multicycle_ctrl_fsm (MEM_TIMEOUT 16 and 4 instances).
module tb_multicycle_ctrl_fsm;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // {PCWrite,PCWriteCond,IMemRead,IRWrite,LoadRegA,LoadRegB,LoadAOut,
    //  RegWrite,MemToReg,DMemRead,DMemWrite,LoadMDR,ALUSrcA}
    localparam logic [12:0] F_NONE = 13'h0000;
    localparam logic [12:0] F_FWT  = 13'h0400;
    localparam logic [12:0] F_FRDY = 13'h1600;
    localparam logic [12:0] F_DEC  = 13'h01C0;
    localparam logic [12:0] F_EX   = 13'h0041;
    localparam logic [12:0] F_AWB  = 13'h0020;
    localparam logic [12:0] F_MRD  = 13'h0008;
    localparam logic [12:0] F_MRDY = 13'h000A;
    localparam logic [12:0] F_MWB  = 13'h0030;
    localparam logic [12:0] F_MWR  = 13'h0004;
    localparam logic [12:0] F_BR   = 13'h0801;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        z;
        logic        ir;
        logic        dr;
        logic [12:0] fl;
        logic [1:0]  srcb;
        logic [1:0]  aluop;
        logic [1:0]  pcsrc;
        logic        bt;
        logic        tr;
        logic [1:0]  cause;
        logic [63:0] ret;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    multicycle_ctrl_fsm_if #(.RET_W(64)) if_a ();
    multicycle_ctrl_fsm_if #(.RET_W(64)) if_b ();

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(16), .RET_W(64)) dut_a (
        .clk   (clk),
        .reset (rst_n),
        .bus   (if_a)
    );

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(4), .RET_W(64)) dut_b (
        .clk   (clk),
        .reset (rst_n),
        .bus   (if_b)
    );

    wire logic [12:0] a_flags = {if_a.PCWrite, if_a.PCWriteCond, if_a.IMemRead, if_a.IRWrite,
                                 if_a.LoadRegA, if_a.LoadRegB, if_a.LoadAOut, if_a.RegWrite,
                                 if_a.MemToReg, if_a.DMemRead, if_a.DMemWrite, if_a.LoadMDR,
                                 if_a.ALUSrcA};
    wire logic [12:0] b_flags = {if_b.PCWrite, if_b.PCWriteCond, if_b.IMemRead, if_b.IRWrite,
                                 if_b.LoadRegA, if_b.LoadRegB, if_b.LoadAOut, if_b.RegWrite,
                                 if_b.MemToReg, if_b.DMemRead, if_b.DMemWrite, if_b.LoadMDR,
                                 if_b.ALUSrcA};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t V(input logic [6:0] op, input int f3, input int z, input int ir,
                               input int dr, input logic [12:0] fl, input int sb, input int ao,
                               input int ps, input int bt, input int tr, input int c,
                               input int r);
        vec_t v;
        v.op = op;          v.f3 = 3'(f3);     v.z = 1'(z);
        v.ir = 1'(ir);      v.dr = 1'(dr);     v.fl = fl;
        v.srcb = 2'(sb);    v.aluop = 2'(ao);  v.pcsrc = 2'(ps);
        v.bt = 1'(bt);      v.tr = 1'(tr);     v.cause = 2'(c);
        v.ret = 64'(r);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Called at a falling edge: drive, settle, compare, advance to the next falling edge.
    task automatic run_vec(input vec_t v, input string tag);
        if_a.opcode     = v.op;
        if_a.funct3     = v.f3;
        if_a.alu_zero   = v.z;
        if_a.imem_ready = v.ir;
        if_a.dmem_ready = v.dr;
        #1;
        chk({tag, ".flags"}, 64'(a_flags), 64'(v.fl));
        chk({tag, ".sel"},
            64'({if_a.ALUSrcB, if_a.ALUOp, if_a.PCSource, if_a.branch_taken, if_a.trap, if_a.trap_cause}),
            64'({v.srcb, v.aluop, v.pcsrc, v.bt, v.tr, v.cause}));
        chk({tag, ".instret"}, if_a.instret, v.ret);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step_b(input logic ir);
        if_b.imem_ready = ir;
        #1;
    endtask

    vec_t tbl[$];
    vec_t rst_seq[$];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        {if_a.opcode, if_a.funct3, if_a.alu_zero, if_a.imem_ready, if_a.dmem_ready} = '0;
        {if_b.opcode, if_b.funct3, if_b.alu_zero, if_b.imem_ready, if_b.dmem_ready} = '0;

        //        op      f3 z ir dr  flags   sb ao ps bt tr c  ret
        tbl.push_back(V(OP_R,   0,0,1,0, F_NONE, 0,0,0, 0,0,0, 0)); // IDLE
        tbl.push_back(V(OP_R,   0,0,1,0, F_FRDY, 1,0,0, 0,0,0, 0));
        tbl.push_back(V(OP_R,   0,0,1,0, F_DEC,  2,0,0, 0,0,0, 0));
        tbl.push_back(V(OP_R,   0,0,1,0, F_EX,   0,2,0, 0,0,0, 0));
        tbl.push_back(V(OP_R,   0,0,1,0, F_AWB,  0,0,0, 0,0,0, 0));
        tbl.push_back(V(OP_I,   0,0,1,0, F_FRDY, 1,0,0, 0,0,0, 1));
        tbl.push_back(V(OP_I,   0,0,1,0, F_DEC,  2,0,0, 0,0,0, 1));
        tbl.push_back(V(OP_I,   0,0,1,0, F_EX,   2,3,0, 0,0,0, 1));
        tbl.push_back(V(OP_I,   0,0,1,0, F_AWB,  0,0,0, 0,0,0, 1));
        tbl.push_back(V(OP_LD,  3,0,1,0, F_FRDY, 1,0,0, 0,0,0, 2));
        tbl.push_back(V(OP_LD,  3,0,1,0, F_DEC,  2,0,0, 0,0,0, 2));
        tbl.push_back(V(OP_LD,  3,0,1,0, F_EX,   2,0,0, 0,0,0, 2));
        tbl.push_back(V(OP_LD,  3,0,1,0, F_MRD,  0,0,0, 0,0,0, 2));
        tbl.push_back(V(OP_LD,  3,0,1,0, F_MRD,  0,0,0, 0,0,0, 2));
        tbl.push_back(V(OP_LD,  3,0,1,0, F_MRD,  0,0,0, 0,0,0, 2));
        tbl.push_back(V(OP_LD,  3,0,1,1, F_MRDY, 0,0,0, 0,0,0, 2));
        tbl.push_back(V(OP_LD,  3,0,1,0, F_MWB,  0,0,0, 0,0,0, 2));
        tbl.push_back(V(OP_ST,  3,0,1,0, F_FRDY, 1,0,0, 0,0,0, 3));
        tbl.push_back(V(OP_ST,  3,0,1,0, F_DEC,  2,0,0, 0,0,0, 3));
        tbl.push_back(V(OP_ST,  3,0,1,0, F_EX,   2,0,0, 0,0,0, 3));
        tbl.push_back(V(OP_ST,  3,0,1,1, F_MWR,  0,0,0, 0,0,0, 3));
        tbl.push_back(V(OP_BR,  1,0,1,0, F_FRDY, 1,0,0, 0,0,0, 4)); // BNE, not equal
        tbl.push_back(V(OP_BR,  1,0,1,0, F_DEC,  2,0,0, 0,0,0, 4));
        tbl.push_back(V(OP_BR,  1,0,1,0, F_BR,   0,1,1, 1,0,0, 4));
        tbl.push_back(V(OP_BR,  1,1,1,0, F_FRDY, 1,0,0, 0,0,0, 5)); // BNE, equal
        tbl.push_back(V(OP_BR,  1,1,1,0, F_DEC,  2,0,0, 0,0,0, 5));
        tbl.push_back(V(OP_BR,  1,1,1,0, F_BR,   0,1,1, 0,0,0, 5));
        tbl.push_back(V(OP_BR,  0,1,1,0, F_FRDY, 1,0,0, 0,0,0, 6)); // BEQ, equal
        tbl.push_back(V(OP_BR,  0,1,1,0, F_DEC,  2,0,0, 0,0,0, 6));
        tbl.push_back(V(OP_BR,  0,1,1,0, F_BR,   0,1,1, 1,0,0, 6));
        tbl.push_back(V(OP_R,   0,0,0,0, F_FWT,  1,0,0, 0,0,0, 7)); // fetch waits twice
        tbl.push_back(V(OP_R,   0,0,0,0, F_FWT,  1,0,0, 0,0,0, 7));
        tbl.push_back(V(OP_R,   0,0,1,0, F_FRDY, 1,0,0, 0,0,0, 7));
        tbl.push_back(V(OP_R,   0,0,1,0, F_DEC,  2,0,0, 0,0,0, 7));
        tbl.push_back(V(OP_R,   0,0,1,0, F_EX,   0,2,0, 0,0,0, 7));
        tbl.push_back(V(OP_R,   0,0,1,0, F_AWB,  0,0,0, 0,0,0, 7));
        tbl.push_back(V(OP_BAD, 0,0,1,0, F_FRDY, 1,0,0, 0,0,0, 8));
        tbl.push_back(V(OP_BAD, 0,0,1,0, F_DEC,  2,0,0, 0,0,0, 8));
        tbl.push_back(V(OP_BAD, 0,0,1,0, F_NONE, 0,0,0, 0,1,1, 8)); // TRAP, illegal

        rst_seq.push_back(V(OP_ST, 3,0,1,0, F_NONE, 0,0,0, 0,0,0, 0));
        rst_seq.push_back(V(OP_ST, 3,0,1,0, F_FRDY, 1,0,0, 0,0,0, 0));
        rst_seq.push_back(V(OP_ST, 3,0,1,0, F_DEC,  2,0,0, 0,0,0, 0));
        rst_seq.push_back(V(OP_ST, 3,0,1,0, F_EX,   2,0,0, 0,0,0, 0));
        rst_seq.push_back(V(OP_ST, 3,0,1,0, F_MWR,  0,0,0, 0,0,0, 0));

        // Reset state
        @(negedge clk);
        #1;
        chk("reset.flags",   64'(a_flags), 64'(F_NONE));
        chk("reset.trap",    64'({if_a.trap, if_a.trap_cause}), 64'(0));
        chk("reset.instret", if_a.instret, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Illegal-opcode trap must hold with flags low regardless of inputs
        for (int k = 0; k < 20; k++) begin
            if_a.imem_ready = 1'b1;
            if_a.dmem_ready = k[0];
            if_a.opcode     = OP_R;
            #1;
            chk($sformatf("trap_hold%0d", k),
                64'({a_flags, if_a.trap, if_a.trap_cause, if_a.instret[7:0]}),
                64'({F_NONE, 1'b1, 2'b01, 8'd8}));
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("trap_reset", 64'({a_flags, if_a.trap, if_a.trap_cause, if_a.instret[7:0]}), 64'(0));

        // MEM_TIMEOUT=4 instance: fetch never ready
        do_reset();
        step_b(1'b0);
        chk("to_idle", 64'(b_flags), 64'(F_NONE));
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            step_b(1'b0);
            chk($sformatf("to_fetch%0d", k), 64'({b_flags, if_b.trap}), 64'({F_FWT, 1'b0}));
            @(negedge clk);
        end
        step_b(1'b0);
        chk("to_trap", 64'({b_flags, if_b.trap, if_b.trap_cause}), 64'({F_NONE, 1'b1, 2'b10}));

        // Ready arriving on the limit cycle wins
        do_reset();
        if_b.opcode = OP_R;
        step_b(1'b0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            step_b(1'b0);
            @(negedge clk);
        end
        step_b(1'b1);
        chk("lim_ready", 64'({b_flags, if_b.trap}), 64'({F_FRDY, 1'b0}));
        @(negedge clk);
        step_b(1'b1);
        chk("lim_decode", 64'({b_flags, if_b.trap, if_b.trap_cause}), 64'({F_DEC, 1'b0, 2'b00}));

        // Reset asserted mid-store drops DMemWrite at once and restarts cleanly
        do_reset();
        foreach (rst_seq[i]) run_vec(rst_seq[i], $sformatf("rstw%0d", i));
        if_a.dmem_ready = 1'b0;
        #1;
        chk("rstw_held", 64'(a_flags), 64'(F_MWR));
        #2 rst_n = 1'b0;
        if_a.dmem_ready = 1'b1;
        #1;
        chk("rstw_abort", 64'({a_flags, if_a.instret[7:0]}), 64'({F_NONE, 8'd0}));
        @(negedge clk);
        rst_n = 1'b1;
        foreach (rst_seq[i]) begin
            vec_t v;
            v = rst_seq[i];
            v.dr = (i == 4) ? 1'b1 : 1'b0;
            run_vec(v, $sformatf("rstr%0d", i));
        end
        run_vec(V(OP_R, 0,0,0,0, F_FWT, 1,0,0, 0,0,0, 1), "rstr_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
